// File: rtl/adda_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adda_pkg
//  Description : Shared types and constants for the J2 ADC/DAC sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package adda_pkg;

    // DAC source selection, encoded as the 2-bit i_src_sel input
    typedef enum logic [1:0] {
        SRC_LOOP = 2'd0,
        SRC_RAMP = 2'd1,
        SRC_HOST = 2'd2,
        SRC_HOLD = 2'd3
    } src_e;

    // Sequencer control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // DAC word played while the ADC pipeline is being primed
    localparam logic [7:0] DAC_MIDSCALE = 8'h80;

endpackage
`default_nettype wire

// File: rtl/adda_clkgen.sv
`default_nettype none
// ============================================================================
//  Module      : adda_clkgen
//  Description : Converter clock generator. Produces o_ad_clk / o_da_clk with a
//                half period of (i_div_q+1) cycles, a combinational rise
//                strobe (the edge where o_ad_clk goes high) and a period-end
//                strobe used to finish a stop request cleanly.
//  Revision    : 1.0 - initial release
// ============================================================================
module adda_clkgen #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_stop,
    input  logic [DIV_W-1:0] i_div_q,
    output logic             o_ad_clk,
    output logic             o_da_clk,
    output logic             o_rise,
    output logic             o_period_end
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_fresh;
    logic [DIV_W-1:0] w_cnt_next;
    logic             w_fresh_next;
    logic             w_ad_next;
    logic             w_da_next;
    logic             w_active;
    logic             w_phase_end;
    logic             w_low_done;

    // r_fresh lets the very first rise happen on the edge right after start,
    // without waiting out a low phase.
    assign w_active     = i_run | i_stop;
    assign w_phase_end  = (r_cnt == i_div_q);
    assign w_low_done   = ~o_ad_clk & (w_phase_end | r_fresh);
    assign o_rise       = i_run & w_low_done;
    assign o_period_end = i_stop & w_low_done;

    // Phase counter and clock next-state decode
    always_comb begin
        w_cnt_next   = r_cnt + DIV_W'(1);
        w_ad_next    = o_ad_clk;
        w_fresh_next = r_fresh;
        if (!w_active) begin
            w_cnt_next   = '0;
            w_ad_next    = 1'b0;
            w_fresh_next = 1'b1;
        end else if (o_rise) begin
            w_cnt_next   = '0;
            w_ad_next    = 1'b1;
            w_fresh_next = 1'b0;
        end else if (o_period_end) begin
            w_cnt_next   = '0;
            w_ad_next    = 1'b0;
        end else if (o_ad_clk && w_phase_end) begin
            w_cnt_next   = '0;
            w_ad_next    = 1'b0;
        end
        // DAC clock is the registered complement while active, forced low at stop
        w_da_next = w_active & ~o_period_end & ~w_ad_next;
    end

    // Clock and counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_fresh  <= 1'b1;
            o_ad_clk <= 1'b0;
            o_da_clk <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_fresh  <= w_fresh_next;
            o_ad_clk <= w_ad_next;
            o_da_clk <= w_da_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adda_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adda_sequencer
//  Description : Sample-rate controller for the J2 8-bit ADC/DAC pair. Runs the
//                converter clocks, discards the ADC pipeline warm-up samples,
//                strobes captured words and selects the DAC source.
//  Revision    : 1.0 - initial release
// ============================================================================
module adda_sequencer
    import adda_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int ADC_LATENCY = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [DIV_W-1:0] i_div,
    input  logic [1:0]       i_src_sel,
    input  logic [7:0]       i_host_data,
    input  logic             i_host_valid,
    output logic             o_host_ready,
    output logic             o_ad_clk,
    input  logic [7:0]       i_ad_data,
    output logic             o_da_clk,
    output logic [7:0]       o_da_data,
    output logic [7:0]       o_sample,
    output logic             o_sample_valid,
    output logic             o_underrun,
    output logic             o_busy
);

    localparam int             PC_W       = $clog2(ADC_LATENCY + 2);
    localparam logic [PC_W-1:0] PRIME_LAST = PC_W'(ADC_LATENCY - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [DIV_W-1:0] r_div_q;
    logic [PC_W-1:0]  r_prime_cnt;
    logic [7:0]       r_ramp;
    logic             w_start;
    logic             w_rise;
    logic             w_period_end;
    logic             w_run;
    logic             w_stop;
    src_e             w_src;

    assign w_src  = src_e'(i_src_sel);
    assign w_run  = (r_state == ST_PRIME) || (r_state == ST_RUN);
    assign w_stop = (r_state == ST_STOP);

    adda_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_run        (w_run),
        .i_stop       (w_stop),
        .i_div_q      (r_div_q),
        .o_ad_clk     (o_ad_clk),
        .o_da_clk     (o_da_clk),
        .o_rise       (w_rise),
        .o_period_end (w_period_end)
    );

    // Next-state decode; a disable always wins over the PRIME->RUN move
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    w_start      = 1'b1;
                    w_state_next = (ADC_LATENCY == 0) ? ST_RUN : ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (!i_enable)
                    w_state_next = ST_STOP;
                else if (w_rise && (r_prime_cnt == PRIME_LAST))
                    w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!i_enable)
                    w_state_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_period_end)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register and busy flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            o_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            o_busy  <= (w_state_next != ST_IDLE);
        end
    end

    // Start-time latches and prime/ramp counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_q     <= '0;
            r_prime_cnt <= '0;
            r_ramp      <= 8'd0;
        end else if (w_start) begin
            r_div_q     <= i_div;
            r_prime_cnt <= '0;
            r_ramp      <= 8'd0;
        end else if (w_rise) begin
            if (r_state == ST_PRIME)
                r_prime_cnt <= r_prime_cnt + PC_W'(1);
            else
                r_ramp <= r_ramp + 8'd1;
        end
    end

    // Sample capture, DAC source mux and host handshake at each rise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sample       <= 8'd0;
            o_sample_valid <= 1'b0;
            o_host_ready   <= 1'b0;
            o_da_data      <= DAC_MIDSCALE;
            o_underrun     <= 1'b0;
        end else begin
            o_sample_valid <= 1'b0;
            o_host_ready   <= 1'b0;
            if (w_start) begin
                o_da_data  <= DAC_MIDSCALE;
                o_underrun <= 1'b0;
            end
            if (w_rise) begin
                o_sample <= i_ad_data;
                if (r_state == ST_PRIME) begin
                    o_da_data <= DAC_MIDSCALE;
                end else begin
                    o_sample_valid <= 1'b1;
                    case (w_src)
                        SRC_LOOP: o_da_data <= i_ad_data;
                        SRC_RAMP: o_da_data <= r_ramp;
                        SRC_HOST: begin
                            o_host_ready <= 1'b1;
                            if (i_host_valid)
                                o_da_data <= i_host_data;
                            else
                                o_underrun <= 1'b1;
                        end
                        default: o_da_data <= o_da_data;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adda_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adda_sequencer
//  Description : Self-checking bench for adda_sequencer. A time-based reference
//                model predicts every output each cycle from the start edge,
//                the latched divider and the converter period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adda_sequencer;

    localparam int DIV_W = 16;
    localparam int LAT   = 3;
    localparam logic [21:0] RESET_VEC = {1'b0, 1'b0, 8'h80, 8'h00, 4'b0000};

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             en    = 1'b0;
    logic [DIV_W-1:0] div   = '0;
    logic [1:0]       src   = 2'd0;
    logic [7:0]       hd    = 8'd0;
    logic             hv    = 1'b0;
    logic [7:0]       ad    = 8'd0;

    logic       host_ready, ad_clk, da_clk, sample_valid, underrun, busy;
    logic [7:0] da_data, sample;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    adda_sequencer #(.DIV_W(DIV_W), .ADC_LATENCY(LAT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (en),
        .i_div          (div),
        .i_src_sel      (src),
        .i_host_data    (hd),
        .i_host_valid   (hv),
        .o_host_ready   (host_ready),
        .o_ad_clk       (ad_clk),
        .i_ad_data      (ad),
        .o_da_clk       (da_clk),
        .o_da_data      (da_data),
        .o_sample       (sample),
        .o_sample_valid (sample_valid),
        .o_underrun     (underrun),
        .o_busy         (busy)
    );

    // ---------------- reference model ----------------
    logic       m_active, m_stopping;
    int         m_t, m_p, m_nr, m_ph;
    logic [DIV_W-1:0] m_d;
    logic [7:0] m_ramp;
    logic       e_ad, e_da, e_valid, e_ready, e_under, e_busy;
    logic [7:0] e_da_data, e_sample;

    logic [21:0] dut_vec, exp_vec;
    assign dut_vec = {ad_clk, da_clk, da_data, sample, sample_valid, host_ready, underrun, busy};
    assign exp_vec = {e_ad, e_da, e_da_data, e_sample, e_valid, e_ready, e_under, e_busy};

    // Time since start t: rises at t = 1 + k*P, clock high for the first half of each period
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0; m_stopping = 1'b0; m_t = 0; m_p = 2; m_nr = 0; m_d = '0; m_ramp = 8'd0;
            e_ad = 1'b0; e_da = 1'b0; e_da_data = 8'h80; e_sample = 8'h00;
            e_valid = 1'b0; e_ready = 1'b0; e_under = 1'b0; e_busy = 1'b0;
        end else begin
            e_valid = 1'b0;
            e_ready = 1'b0;
            if (!m_active) begin
                e_ad = 1'b0; e_da = 1'b0;
                if (en) begin
                    m_active = 1'b1; m_stopping = 1'b0; m_t = 0; m_d = div;
                    m_p = 2 * (int'(div) + 1); m_nr = 0; m_ramp = 8'd0;
                    e_under = 1'b0; e_da_data = 8'h80; e_busy = 1'b1;
                end else begin
                    e_busy = 1'b0;
                end
            end else begin
                m_t = m_t + 1;
                m_ph = (m_t - 1) % m_p;
                if (m_stopping && m_ph == 0) begin
                    m_active = 1'b0; e_ad = 1'b0; e_da = 1'b0; e_busy = 1'b0;
                end else begin
                    if (!m_stopping && m_ph == 0) begin
                        m_nr = m_nr + 1;
                        e_sample = ad;
                        if (m_nr > LAT) begin
                            e_valid = 1'b1;
                            case (src)
                                2'd0: e_da_data = ad;
                                2'd1: e_da_data = m_ramp;
                                2'd2: begin
                                    e_ready = 1'b1;
                                    if (hv) e_da_data = hd;
                                    else    e_under = 1'b1;
                                end
                                default: ;
                            endcase
                            m_ramp = m_ramp + 8'd1;
                        end else begin
                            e_da_data = 8'h80;
                        end
                    end
                    e_ad = (m_ph < int'(m_d) + 1);
                    e_da = ~e_ad;
                    if (!en) m_stopping = 1'b1;
                end
            end
        end
    end

    // Synchronous-to-negedge reset sequence used to isolate scenarios
    task automatic apply_reset();
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (dut_vec !== RESET_VEC) begin fails++; $display("FAIL reset_initial: got %h want %h", dut_vec, RESET_VEC); end
        @(negedge clk);
        rst_n = 1'b1;
        div = 16'd1; src = 2'd0; en = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL reset_run cyc %0d: got %h want %h", k, dut_vec, exp_vec); end
            ad = 8'($urandom);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (dut_vec !== RESET_VEC) begin fails++; $display("FAIL reset_midrun: got %h want %h", dut_vec, RESET_VEC); end
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_loopback_latency();
        int first_valid = -1;
        apply_reset();
        div = 16'd0; src = 2'd0; ad = 8'h5A; en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL loop cyc %0d: got %h want %h", k, dut_vec, exp_vec); end
            if (k < 7) begin
                vectors++;
                if (da_data !== 8'h80) begin fails++; $display("FAIL loop_midscale cyc %0d: got %h want 80", k, da_data); end
            end
            if (first_valid < 0 && sample_valid === 1'b1) begin
                first_valid = k;
                vectors++;
                if (sample !== 8'h5A || da_data !== 8'h5A) begin
                    fails++; $display("FAIL loop_first_word: got %h/%h want 5a/5a", sample, da_data);
                end
            end
        end
        vectors++;
        if (first_valid != 7) begin fails++; $display("FAIL loop_first_valid: got E%0d want E7", first_valid); end
    endtask

    task automatic test_ramp();
        int nvalid = 0;
        int last_k = -1;
        apply_reset();
        div = 16'd2; src = 2'd1; en = 1'b1;
        for (int k = 0; k < 1650; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL ramp cyc %0d: got %h want %h", k, dut_vec, exp_vec); end
            if (sample_valid === 1'b1) begin
                vectors++;
                if (da_data !== 8'(nvalid)) begin fails++; $display("FAIL ramp_value: got %h want %h", da_data, 8'(nvalid)); end
                if (last_k >= 0 && (k - last_k) != 6) begin
                    vectors++; fails++; $display("FAIL ramp_spacing: got %0d want 6", k - last_k);
                end
                last_k = k;
                nvalid++;
            end
            ad = 8'($urandom);
            if (k == 100) div = 16'd7;
        end
        vectors++;
        if (nvalid <= 256) begin fails++; $display("FAIL ramp_wrap_count: got %0d want >256", nvalid); end
    endtask

    task automatic test_host();
        logic seen = 1'b0;
        int   budget;
        apply_reset();
        div = 16'd1; src = 2'd2; en = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL host cyc %0d: got %h want %h", k, dut_vec, exp_vec); end
            if (seen && underrun !== 1'b1) begin
                vectors++; fails++; $display("FAIL host_sticky cyc %0d: got %b want 1", k, underrun);
            end
            if (underrun === 1'b1) seen = 1'b1;
            hv = ($urandom_range(0, 3) != 0);
            hd = 8'($urandom);
            ad = 8'($urandom);
        end
        vectors++;
        if (!seen) begin fails++; $display("FAIL host_underrun_seen: got 0 want 1"); end
        en = 1'b0;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
            vectors++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL host_stop: got %h want %h", dut_vec, exp_vec); end
        end while (busy === 1'b1 && budget < 40);
        vectors++;
        if (busy !== 1'b0 || underrun !== 1'b1) begin fails++; $display("FAIL host_idle: got busy %b und %b want 0 1", busy, underrun); end
        en = 1'b1;
        @(negedge clk);
        vectors++;
        if (underrun !== 1'b0) begin fails++; $display("FAIL host_restart_clear: got %b want 0", underrun); end
    endtask

    task automatic test_stop_on_r();
        int budget = 0;
        apply_reset();
        div = 16'($urandom_range(0, 3)); src = 2'd0; en = 1'b1;
        do begin
            @(negedge clk);
            budget++;
            vectors++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL stopr_pre: got %h want %h", dut_vec, exp_vec); end
            ad = 8'($urandom);
        end while (!(m_active && !m_stopping && m_nr >= LAT + 2 && (m_t % m_p) == 0) && budget < 200);
        en = 1'b0;
        @(negedge clk);
        vectors++;
        if (sample_valid !== 1'b1 || sample !== e_sample) begin
            fails++; $display("FAIL stopr_last_valid: got %b/%h want 1/%h", sample_valid, sample, e_sample);
        end
        budget = 0;
        while (busy === 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
            vectors++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL stopr_drain: got %h want %h", dut_vec, exp_vec); end
            vectors++;
            if (sample_valid !== 1'b0) begin fails++; $display("FAIL stopr_no_valid: got 1 want 0"); end
        end
        vectors++;
        if (busy !== 1'b0 || ad_clk !== 1'b0 || da_clk !== 1'b0) begin
            fails++; $display("FAIL stopr_end: got busy %b clks %b%b want 0 00", busy, ad_clk, da_clk);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL stopr_idle: got %h want %h", dut_vec, exp_vec); end
        end
    endtask

    task automatic test_reenable_in_stop();
        int budget = 0;
        int k_idle = -1;
        int k_valid = -1;
        apply_reset();
        div = 16'd3; src = 2'd1; en = 1'b1;
        do begin
            @(negedge clk);
            budget++;
            vectors++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL reen_pre: got %h want %h", dut_vec, exp_vec); end
        end while (!(budget > 40 && (m_t % m_p) == 3) && budget < 80);
        en = 1'b0;
        @(negedge clk);
        vectors++;
        if (dut_vec !== exp_vec) begin fails++; $display("FAIL reen_drop: got %h want %h", dut_vec, exp_vec); end
        en = 1'b1;
        for (int k = 0; k < 150 && k_valid < 0; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL reen cyc %0d: got %h want %h", k, dut_vec, exp_vec); end
            if (k_idle < 0 && busy === 1'b0) k_idle = k;
            if (k_idle >= 0 && sample_valid === 1'b1) k_valid = k;
        end
        vectors++;
        if (k_idle < 0 || k_valid - k_idle != 2 + LAT * 8) begin
            fails++; $display("FAIL reen_prime_len: got %0d want %0d", k_valid - k_idle, 2 + LAT * 8);
        end
    endtask

    task automatic test_random();
        apply_reset();
        div = 16'd0; src = 2'd0; en = 1'b1;
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL random cyc %0d: got %h want %h", k, dut_vec, exp_vec); end
            ad  = 8'($urandom);
            hd  = 8'($urandom);
            hv  = ($urandom_range(0, 2) != 0);
            div = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) src = 2'($urandom);
            if (en) en = ($urandom_range(0, 99) != 0);
            else    en = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_loopback_latency();
        test_ramp();
        test_host();
        test_stop_on_r();
        test_reenable_in_stop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adda_sequencer.md
# adda_sequencer

Sample-rate controller for the J2 8-bit ADC/DAC pair on the ULX3S. Generates the converter clocks at a programmable rate and captures ADC words with a configurable pipeline discard. It also selects what the DAC plays: loopback, ramp, host stream or hold. It sits between the board top level (J2 pins) and any consumer/producer logic, replacing free-running counter-derived converter clocks.

## Interface
Parameters:
- DIV_W, 16, width of half-period divider
- ADC_LATENCY, 3, number of initial ADC captures discarded after start (converter pipeline depth)

Ports:
- i_clk  in  1  system clock (25 MHz)
- i_rst_n  in  1  reset, asynchronous, active-low
- i_enable  in  1  level; high = run conversions
- i_div  in  DIV_W  half-period minus one, in i_clk cycles; latched at start only
- i_src_sel  in  2  DAC source: 0 loopback, 1 ramp, 2 host, 3 hold
- i_host_data  in  8  host DAC word
- i_host_valid  in  1  host word available
- o_host_ready  out  1  host word consumed this cycle
- o_ad_clk  out  1  ADC conversion clock
- i_ad_data  in  8  ADC output bus (J2_AD_PORT)
- o_da_clk  out  1  DAC latch clock
- o_da_data  out  8  DAC input bus (J2_DA_PORT)
- o_sample  out  8  captured ADC word
- o_sample_valid  out  1  one-cycle strobe, o_sample new
- o_underrun  out  1  sticky: host source starved
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, PRIME, RUN, STOP.
- IDLE: o_ad_clk=0, o_da_clk=0. On i_enable=1, latch i_div into div_q, clear o_underrun, clear prime counter, go to PRIME.
- Period: 2*(div_q+1) cycles. High phase is div_q+1 cycles, then low phase is div_q+1 cycles.
- In PRIME/RUN/STOP, o_da_clk = ~o_ad_clk (registered, not a combinational invert).
- R event: the edge where o_ad_clk goes 0->1. At every R:
  - o_sample <= i_ad_data.
  - o_da_data updates per source.
  - DAC therefore gets a half period of setup before o_da_clk rises.
- PRIME: the first ADC_LATENCY R events capture without asserting o_sample_valid. o_da_data is held at 8'h80 (midscale). Move to RUN after the ADC_LATENCY-th R.
- RUN: every R pulses o_sample_valid for one cycle. Sources:
  - loopback: o_da_data <= i_ad_data (same word as o_sample).
  - ramp: internal 8-bit counter, +1 per R, wraps 255->0; reset to 0 on entering PRIME.
  - host: o_host_ready=1 only on the R cycle. If i_host_valid, o_da_data <= i_host_data. Else hold o_da_data and set o_underrun.
  - hold: o_da_data unchanged.
- A change of i_src_sel takes effect at the next R. A change of i_div is ignored until the next start.
- i_enable=0 in PRIME/RUN: go to STOP. STOP finishes the current period (low phase ends), forces both clocks to 0, then goes to IDLE. No R occurs in STOP.
- i_enable=0 on an R cycle: that R completes fully (capture, valid if in RUN, DAC update), then STOP.
- i_enable=1 again while in STOP: ignored until IDLE is reached; restart then goes through PRIME.

## Timing
- Reset values: o_ad_clk=0, o_da_clk=0, o_da_data=8'h80, o_sample=0, o_sample_valid=0, o_host_ready=0, o_underrun=0, o_busy=0. All outputs take these values immediately on i_rst_n low, including mid-operation.
- All outputs are registered.
- Start latency: i_enable sampled high at edge E0 (IDLE->PRIME). The first R is at E1.
- The R edge updates o_ad_clk, o_sample, o_sample_valid and o_da_data simultaneously.
- First o_sample_valid: R number ADC_LATENCY+1, i.e. E1 + ADC_LATENCY*2*(div_q+1).
- i_div=0 gives 12.5 MHz converter clocks. Maximum i_div = 2^DIV_W-1.
- o_host_ready and o_sample_valid are never high for more than one consecutive cycle.

## Structure
- Package adda_pkg holds:
  - source-select enum (SRC_LOOP, SRC_RAMP, SRC_HOST, SRC_HOLD)
  - state enum
  - DAC_MIDSCALE = 8'h80
- Sub-module adda_clkgen:
  - phase counter, o_ad_clk/o_da_clk registers, R strobe, period-end strobe
  - inputs: run, stop request, div_q
- adda_sequencer holds the FSM, prime counter, source mux, ramp counter and handshake.

## Test plan
- Reset mid-RUN (i_div=1): assert i_rst_n=0 asynchronously -> all outputs reach reset values before the next i_clk edge; o_da_data=8'h80.
- Start, i_div=0, ADC_LATENCY=3, loopback, i_ad_data=8'h5A -> o_ad_clk period 2 cycles; first o_sample_valid at E7 with o_sample=8'h5A and o_da_data=8'h5A; o_da_data=8'h80 before that.
- Ramp, i_div=2 -> o_da_data 0,1,2… at 6-cycle spacing; wraps 8'hFF->8'h00; i_div change mid-run leaves period at 6.
- Host source, i_host_valid low for one R -> o_host_ready pulses, o_da_data holds, o_underrun=1 and stays set until the next start.
- Deassert i_enable on an R cycle -> that sample is valid, low phase completes, both clocks end at 0, o_busy falls; no further o_sample_valid.
- Re-enable while in STOP -> no R until IDLE; restart repeats the full PRIME (3 discarded samples).
